// File: rtl/bp_pkg.sv
// Shared branch-prediction types: BTB entry layout, control-flow type and counter constants.
// The cnt field exists only when BTB_DIR_COUNTER_EN is defined.
package bp_pkg;

    localparam int unsigned BP_XLEN        = 32;
    localparam int unsigned BP_BTB_ADDRESS = 4;
    localparam int unsigned BP_TAG_W       = BP_XLEN - BP_BTB_ADDRESS - 2;

    localparam logic [1:0] CNT_WEAK_T = 2'b10;
    localparam logic [1:0] CNT_MAX    = 2'b11;

    typedef enum logic [1:0] {
        BTB_BR   = 2'd0,
        BTB_JAL  = 2'd1,
        BTB_CALL = 2'd2,
        BTB_RET  = 2'd3
    } btb_type_t;

    typedef struct packed {
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
        btb_type_t           typ;
`ifdef BTB_DIR_COUNTER_EN
        logic [1:0]          cnt;
`endif
    } btb_entry_t;

    // Unconditional transfers always redirect; a branch redirects once its counter is weakly taken.
    function automatic logic slot_taken(input btb_type_t typ, input logic [1:0] cnt);
        return (typ != BTB_BR) || (cnt >= CNT_WEAK_T);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_MAX) begin
                cnt_o = cnt_i + 2'd1;
            end
        end else if (cnt_i != 2'b00) begin
            cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Two-slot branch target buffer: registered prediction for PC and PC+4, trained by execute.
// Optional macro BTB_DIR_COUNTER_EN enables stored 2-bit direction counters.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ADDRESS = 4,
    parameter int unsigned TAG_W       = XLEN - BTB_ADDRESS - 2
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_in,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic [1:0]      upd_type,
    input  logic            upd_taken,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            btb_is_ret1,
    output logic            btb_is_ret2,
    output logic            btb_is_call
);

    localparam int unsigned ENTRIES = 1 << BTB_ADDRESS;

    // The entry struct is sized by the package, so the parameters must agree with it.
    if (XLEN != BP_XLEN || BTB_ADDRESS != BP_BTB_ADDRESS || TAG_W != BP_TAG_W) begin : g_cfg_check
        $error("branch_target_buffer parameters do not match bp_pkg entry layout");
    end

    btb_entry_t         entry_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic            pred_valid_q, pred_taken_q, ret1_q, ret2_q, call_q;
    logic [XLEN-1:0] target_q;
    logic            pred_taken_d, ret1_d, ret2_d, call_d;
    logic [XLEN-1:0] target_d;

    logic [XLEN-1:0]        pc4_c, pc8_c;
    logic [BTB_ADDRESS-1:0] idx1_c, idx2_c, uidx_c;
    logic [TAG_W-1:0]       tag1_c, tag2_c, utag_c;
    btb_entry_t             e1_c, e2_c, ue_c, wr_entry_c;
    logic [1:0]             cnt1_c, cnt2_c, ucnt_c, ucnt_nxt_c;
    logic                   hit1_c, hit2_c, tk1_c, tk2_c, uhit_c;
    logic                   wr_en_c, set_valid_c, clr_valid_c;
    logic                   unused_bits_c;

    assign pc4_c  = pc_in + XLEN'(4);
    assign pc8_c  = pc_in + XLEN'(8);
    assign idx1_c = pc_in[BTB_ADDRESS+1:2];
    assign tag1_c = pc_in[XLEN-1:BTB_ADDRESS+2];
    assign idx2_c = pc4_c[BTB_ADDRESS+1:2];
    assign tag2_c = pc4_c[XLEN-1:BTB_ADDRESS+2];
    assign uidx_c = upd_pc[BTB_ADDRESS+1:2];
    assign utag_c = upd_pc[XLEN-1:BTB_ADDRESS+2];

    assign unused_bits_c = ^{pc4_c[1:0], upd_pc[1:0]};

    // Two asynchronous read ports for lookup, a third for the update read-modify-write.
    assign e1_c = entry_q[idx1_c];
    assign e2_c = entry_q[idx2_c];
    assign ue_c = entry_q[uidx_c];

`ifdef BTB_DIR_COUNTER_EN
    assign cnt1_c = e1_c.cnt;
    assign cnt2_c = e2_c.cnt;
    assign ucnt_c = ue_c.cnt;
`else
    // Without storage every branch behaves as weakly taken; one not-taken step drops it below threshold.
    assign cnt1_c = CNT_WEAK_T;
    assign cnt2_c = CNT_WEAK_T;
    assign ucnt_c = CNT_WEAK_T;
`endif

    sat_counter2 u_sat_counter2 (
        .cnt_i   (ucnt_c),
        .taken_i (upd_taken),
        .cnt_o   (ucnt_nxt_c)
    );

    // Lookup and slot selection; slot 1 has priority and masks slot 2.
    always_comb begin
        hit1_c       = valid_q[idx1_c] && (e1_c.tag == tag1_c);
        hit2_c       = valid_q[idx2_c] && (e2_c.tag == tag2_c);
        tk1_c        = fetch_valid && hit1_c && slot_taken(e1_c.typ, cnt1_c);
        tk2_c        = fetch_valid && hit2_c && slot_taken(e2_c.typ, cnt2_c);
        pred_taken_d = tk1_c || tk2_c;
        target_d     = pc8_c;
        ret1_d       = 1'b0;
        ret2_d       = 1'b0;
        call_d       = 1'b0;
        if (tk1_c) begin
            target_d = e1_c.target;
            ret1_d   = (e1_c.typ == BTB_RET);
            call_d   = (e1_c.typ == BTB_CALL);
        end else if (tk2_c) begin
            target_d = e2_c.target;
            ret2_d   = (e2_c.typ == BTB_RET);
            call_d   = (e2_c.typ == BTB_CALL);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            target_q     <= '0;
            ret1_q       <= 1'b0;
            ret2_q       <= 1'b0;
            call_q       <= 1'b0;
        end else if (!stall) begin
            pred_valid_q <= fetch_valid;
            pred_taken_q <= pred_taken_d;
            target_q     <= target_d;
            ret1_q       <= ret1_d;
            ret2_q       <= ret2_d;
            call_q       <= call_d;
        end
    end

    // Training: hit updates direction/target, taken miss allocates, not-taken miss is dropped.
    always_comb begin
        uhit_c      = valid_q[uidx_c] && (ue_c.tag == utag_c);
        wr_en_c     = 1'b0;
        set_valid_c = 1'b0;
        clr_valid_c = 1'b0;
        wr_entry_c  = ue_c;
        if (upd_valid) begin
            if (uhit_c) begin
                wr_en_c = 1'b1;
`ifdef BTB_DIR_COUNTER_EN
                wr_entry_c.cnt = ucnt_nxt_c;
`endif
                if (upd_taken) begin
                    wr_entry_c.target = upd_target;
                    wr_entry_c.typ    = btb_type_t'(upd_type);
                end
`ifndef BTB_DIR_COUNTER_EN
                else if (ue_c.typ == BTB_BR && ucnt_nxt_c < CNT_WEAK_T) begin
                    clr_valid_c = 1'b1;
                end
`endif
            end else if (upd_taken) begin
                wr_en_c           = 1'b1;
                set_valid_c       = 1'b1;
                wr_entry_c.tag    = utag_c;
                wr_entry_c.target = upd_target;
                wr_entry_c.typ    = btb_type_t'(upd_type);
`ifdef BTB_DIR_COUNTER_EN
                wr_entry_c.cnt    = CNT_WEAK_T;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            entry_q[uidx_c] <= wr_entry_c;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (set_valid_c) begin
            valid_q[uidx_c] <= 1'b1;
        end else if (clr_valid_c) begin
            valid_q[uidx_c] <= 1'b0;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = target_q;
    assign btb_is_ret1 = ret1_q;
    assign btb_is_ret2 = ret2_q;
    assign btb_is_call = call_q;

endmodule
